// File: rtl/clk_div_monitor_pkg.sv
// Shared types and default constants for the divided-clock monitor.
// The state encoding is fixed so debug tooling can decode the raw state bits.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_EXP_PERIOD = 3;
  localparam int unsigned DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/clk_div_monitor_edge_sample.sv
// Samples the divided clock in the source clk domain and flags rising edges.
// The rise flag is combinational from the two history flops.
module clk_div_monitor_edge_sample (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);

  logic s_q;
  logic s_dly_q;

  // two-deep sample history of the divided clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      s_q     <= d_i;
      s_dly_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in source-clock cycles,
// tracks lock against an expected period and flags mismatches and overflow.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             div_in_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             err_period_o,
  output logic             overflow_o
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   EXP_CNT    = CNT_W'(EXP_PERIOD);
  localparam logic [MATCH_W-1:0] MATCH_ZERO = {MATCH_W{1'b0}};
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1'b1);
  localparam logic [MATCH_W-1:0] LOCK_MATCH = MATCH_W'(LOCK_COUNT);

  logic s_s;
  logic rise_s;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [CNT_W-1:0]   hcnt_q,   hcnt_d;
  logic [MATCH_W-1:0] match_q,  match_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q,   high_d;
  logic               valid_q,  valid_d;
  logic               locked_q, locked_d;
  logic               err_q,    err_d;
  logic               ovf_q,    ovf_d;

  clk_div_monitor_edge_sample u_edge_sample (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (div_in_i),
    .s_o    (s_s),
    .rise_o (rise_s)
  );

  // next-state and measurement update; pulses default low every cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    match_d  = match_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    ovf_d    = ovf_q;
    if (!en_i) begin
      state_d  = ST_IDLE;
      cnt_d    = CNT_ZERO;
      hcnt_d   = CNT_ZERO;
      match_d  = MATCH_ZERO;
      period_d = CNT_ZERO;
      high_d   = CNT_ZERO;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d    = CNT_ZERO;
          hcnt_d   = CNT_ZERO;
          match_d  = MATCH_ZERO;
          locked_d = 1'b0;
          state_d  = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (rise_s) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = ST_MEASURE;
          end else begin
            state_d = ST_WAIT_RISE;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            valid_d  = 1'b1;
            period_d = cnt_q;
            high_d   = hcnt_q;
            cnt_d    = CNT_ONE;
            hcnt_d   = CNT_ONE;
            if (cnt_q == EXP_CNT) begin
              if (match_q != LOCK_MATCH) begin
                match_d = match_q + MATCH_ONE;
              end else begin
                match_d = match_q;
              end
              locked_d = (match_d == LOCK_MATCH);
            end else begin
              err_d    = 1'b1;
              match_d  = MATCH_ZERO;
              locked_d = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            // no edge within the counter range: give up on this period
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = MATCH_ZERO;
            cnt_d    = CNT_ZERO;
            hcnt_d   = CNT_ZERO;
            state_d  = ST_WAIT_RISE;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            hcnt_d = hcnt_q + CNT_W'(s_s);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      hcnt_q   <= CNT_ZERO;
      match_q  <= MATCH_ZERO;
      period_q <= CNT_ZERO;
      high_q   <= CNT_ZERO;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period_o     = period_q;
  assign high_time_o  = high_q;
  assign meas_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign err_period_o = err_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: a directed vector table, corner-case sequences and
// randomized waveforms checked against a rise-index based reference model.
module tb_clk_div_monitor;

  localparam int EXP  = 3;
  localparam int LOCK = 4;
  localparam int MAXC = 255;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_MEAS = 2;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       en = 1'b0;
  logic       div = 1'b0;
  logic [7:0] period, high_time;
  logic       mv, locked, err, ovf;

  logic       en4 = 1'b0;
  logic       div4 = 1'b0;
  logic [3:0] period4, high4;
  logic       mv4, locked4, err4, ovf4;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit hist[$];
  int mode, r_idx, match;
  int e_period, e_high, e_valid, e_err, e_locked, e_ovf;

  typedef struct {
    logic en;
    logic div;
    int   valid;
    int   period;
    int   high;
    int   err;
    int   locked;
  } vec_t;

  vec_t tbl[28];

  always #5 clk = ~clk;

  clk_div_monitor dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .div_in_i(div),
    .period_o(period), .high_time_o(high_time), .meas_valid_o(mv),
    .locked_o(locked), .err_period_o(err), .overflow_o(ovf)
  );

  clk_div_monitor #(.CNT_W(4), .EXP_PERIOD(3), .LOCK_COUNT(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en4), .div_in_i(div4),
    .period_o(period4), .high_time_o(high4), .meas_valid_o(mv4),
    .locked_o(locked4), .err_period_o(err4), .overflow_o(ovf4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    mode = M_IDLE; r_idx = 0; match = 0;
    e_period = 0; e_high = 0; e_valid = 0; e_err = 0; e_locked = 0; e_ovf = 0;
  endtask

  // hist[i] is div_in as sampled at the i-th edge; a period is the distance
  // between two rise sample indices, high time the ones inside that window
  task automatic model_edge(input logic en_v, input logic div_v);
    int n;
    bit rise;
    n = hist.size() - 1;
    rise = hist[n] && !hist[n-1];
    e_valid = 0;
    e_err = 0;
    if (!en_v) begin
      mode = M_IDLE; match = 0;
      e_period = 0; e_high = 0; e_locked = 0; e_ovf = 0;
    end else if (mode == M_IDLE) begin
      mode = M_WAIT; match = 0; e_locked = 0;
    end else if (mode == M_WAIT) begin
      if (rise) begin
        mode = M_MEAS;
        r_idx = n;
      end
    end else begin
      if (rise) begin
        e_valid = 1;
        e_period = n - r_idx;
        e_high = 0;
        for (int i = r_idx; i < n; i++) e_high += int'(hist[i]);
        if (n - r_idx == EXP) begin
          if (match < LOCK) match++;
          e_locked = (match == LOCK) ? 1 : 0;
        end else begin
          e_err = 1; match = 0; e_locked = 0;
        end
        r_idx = n;
      end else if (n - r_idx == MAXC) begin
        e_ovf = 1; e_locked = 0; match = 0; mode = M_WAIT;
      end
    end
    hist.push_back(div_v);
  endtask

  task automatic step(input logic en_v, input logic div_v);
    @(negedge clk);
    en = en_v;
    div = div_v;
    @(posedge clk);
    #1;
    model_edge(en_v, div_v);
    chk("model_period", period, e_period);
    chk("model_high", high_time, e_high);
    chk("model_valid", mv, e_valid);
    chk("model_err", err, e_err);
    chk("model_locked", locked, e_locked);
    chk("model_ovf", ovf, e_ovf);
  endtask

  // asynchronous reset in mid-cycle; outputs must clear without a clock edge
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_period", period, 0);
    chk("arst_high", high_time, 0);
    chk("arst_valid", mv, 0);
    chk("arst_err", err, 0);
    chk("arst_locked", locked, 0);
    chk("arst_ovf", ovf, 0);
    model_reset();
    #1;
    rst_ni = 1'b1;
  endtask

  int ph;
  int nvalid;
  int kind, per, hi, len;

  initial begin
    for (int i = 0; i < 28; i++) begin
      tbl[i].en     = 1'b1;
      tbl[i].div    = (i < 18) ? ((i % 3) == 0) : (((i - 18) % 2) == 0);
      tbl[i].valid  = ((i >= 4 && i <= 19 && (i - 4) % 3 == 0) || (i >= 21 && (i - 21) % 2 == 0)) ? 1 : 0;
      tbl[i].period = (i < 4) ? 0 : ((i < 21) ? 3 : 2);
      tbl[i].high   = (i < 4) ? 0 : 1;
      tbl[i].err    = (i >= 21 && (i - 21) % 2 == 0) ? 1 : 0;
      tbl[i].locked = (i >= 13 && i < 21) ? 1 : 0;
    end

    #12;
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", mv, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    #6;
    rst_ni = 1'b1;
    model_reset();

    // divide-by-3 until locked, then divide-by-2
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].en, tbl[i].div);
      chk("tbl_valid", mv, tbl[i].valid);
      chk("tbl_period", period, tbl[i].period);
      chk("tbl_high", high_time, tbl[i].high);
      chk("tbl_err", err, tbl[i].err);
      chk("tbl_locked", locked, tbl[i].locked);
      chk("tbl_ovf", ovf, 0);
    end

    // lock on divide-by-3, then drop enable for two cycles
    ph = 0;
    for (int j = 0; j < 24; j++) begin
      step(1'b1, (ph % 3) == 0);
      ph++;
    end
    chk("lock_before_en_drop", locked, 1);
    step(1'b0, (ph % 3) == 0); ph++;
    chk("en_drop_locked", locked, 0);
    chk("en_drop_period", period, 0);
    step(1'b0, (ph % 3) == 0); ph++;
    nvalid = 0;
    for (int j = 0; j < 20; j++) begin
      step(1'b1, (ph % 3) == 0);
      ph++;
      if (mv) begin
        nvalid++;
        chk("relock_at_valid", locked, (nvalid >= 4) ? 1 : 0);
      end
    end
    chk("relock_valid_count", (nvalid >= 4) ? 1 : 0, 1);

    // asynchronous reset while locked, then restart from a fresh rise
    chk("lock_before_reset", locked, 1);
    async_reset();
    for (int j = 0; j < 12; j++) begin
      step(1'b1, (ph % 3) == 0);
      ph++;
    end

    // 4-bit counter: one rise then stuck low
    en4 = 1'b1; div4 = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    div4 = 1'b1;
    step(1'b1, 1'b0);
    div4 = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step(1'b1, 1'b0);
      chk("ovf4_timing", ovf4, (j == 16) ? 1 : 0);
      chk("ovf4_no_valid", mv4, 0);
      chk("ovf4_no_err", err4, 0);
      chk("ovf4_period", period4, 0);
      chk("ovf4_high", high4, 0);
    end
    chk("ovf4_locked", locked4, 0);
    step(1'b1, 1'b0);
    chk("ovf4_sticky", ovf4, 1);
    en4 = 1'b0;
    step(1'b1, 1'b0);
    chk("ovf4_clear_on_en", ovf4, 0);

    // randomized waveforms against the model
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) async_reset();
      if (seg == 20) begin
        for (int j = 0; j < 6; j++) step(1'b1, (j % 2) == 0);
        for (int j = 0; j < 270; j++) step(1'b1, 1'b0);
        chk("ovf8_stuck_low", ovf, 1);
      end
      per = $urandom_range(1, 6);
      hi  = $urandom_range(1, per);
      len = $urandom_range(5, 40);
      for (int j = 0; j < len; j++) begin
        step((kind == 2 && j < 2) ? 1'b0 : 1'b1, (ph % per) < hi);
        ph++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
